led_arbiter: RTL and testbench

LED_ARBITER -- requirements
Module: led_arbiter

---
 rtl/led_arb_pkg.sv | 11 +
 rtl/led_arbiter_if.sv | 29 ++
 rtl/rr_picker.sv | 31 +++
 rtl/led_arbiter.sv | 122 ++++++++++++
 tb/tb_led_arbiter.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared state encoding and LED width for the LED bank arbiter
package led_arb_pkg;

   localparam int LED_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

endpackage

// File: rtl/led_arbiter_if.sv
// rtl/led_arbiter_if.sv - request/pattern/grant bundle between requesters and the LED arbiter
interface led_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import led_arb_pkg::*;

   logic [NUM_REQ-1:0]       req;
   logic [LED_W*NUM_REQ-1:0] data;
   logic [NUM_REQ-1:0]       grant;
   logic [LED_W-1:0]         led;
   logic                     busy;

   modport master (
      output req,
      output data,
      input  grant,
      input  led,
      input  busy
   );

   modport slave (
      input  req,
      input  data,
      output grant,
      output led,
      output busy
   );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick starting just after the last owner
module rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] last_i,
   output logic [NUM_REQ-1:0]         winner_o,
   output logic                       valid_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // The last owner is visited last, so it only wins when nobody else asks.
   always_comb begin
      int idx;
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = int'(last_i) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!valid_o && req_i[idx[IDX_W-1:0]]) begin
            winner_o[idx[IDX_W-1:0]] = 1'b1;
            valid_o                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - round-robin owner of the LED bank; LED_ARB_PREEMPT_EN adds time-slice preemption
module led_arbiter
   import led_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 50000000
) (
   input  logic          clk,
   input  logic          rst_n,
   led_arbiter_if.slave  bus
);

   localparam int             IDX_W    = $clog2(NUM_REQ);
   localparam int             CNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [LED_W-1:0]   led_q, led_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_REQ-1:0] win_oh;
   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;
   logic [LED_W-1:0]   slice [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign slice[g] = bus.data[g*LED_W +: LED_W];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_picker (
      .req_i    (bus.req),
      .last_i   (last_q),
      .winner_o (win_oh),
      .valid_o  (win_vld)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end

   // While owning, last_q doubles as the owner index.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      led_d   = led_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            led_d   = '0;
            cnt_d   = '0;
            if (win_vld) begin
               state_d = OWN;
               grant_d = win_oh;
               last_d  = win_idx;
               led_d   = slice[win_idx];
            end
         end
         OWN: begin
            if (!bus.req[last_q]) begin
               state_d = IDLE;
               grant_d = '0;
               led_d   = '0;
               cnt_d   = '0;
            end
`ifdef LED_ARB_PREEMPT_EN
            else if ((cnt_q == HOLD_MAX) && |(bus.req & ~grant_q)) begin
               grant_d = win_oh;
               last_d  = win_idx;
               led_d   = slice[win_idx];
               cnt_d   = '0;
            end
`endif
            else begin
               led_d = slice[last_q];
               if (cnt_q != HOLD_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
      busy_d = |grant_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= LAST_RST;
         grant_q <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.led   = led_q;
   assign bus.busy  = busy_q;

   a_grant_onehot : assert property (@(posedge clk) $onehot0(grant_q));
   a_busy_matches : assert property (@(posedge clk) busy_q == (|grant_q));

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - directed checks of the LED arbiter with NUM_REQ=4, HOLD_CYCLES=4
module tb_led_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   led_arbiter_if #(.NUM_REQ(4)) bus ();

   led_arbiter #(
      .NUM_REQ     (4),
      .HOLD_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      bus.req  = 4'b1111;
      bus.data = {8'h44, 8'h33, 8'h22, 8'h11};
      step();
      step();
      chk("reset_grant", {4'b0, bus.grant}, 8'h00);
      chk("reset_led", bus.led, 8'h00);
      chk("reset_busy", {7'b0, bus.busy}, 8'h00);
      rst_n = 1'b1;
      step();
      chk("post_reset_grant", {4'b0, bus.grant}, 8'h01);
      chk("post_reset_led", bus.led, 8'h11);
      chk("post_reset_busy", {7'b0, bus.busy}, 8'h01);
      bus.req = 4'b0000;
      step();
      chk("drop_idle_grant", {4'b0, bus.grant}, 8'h00);
   endtask

   task automatic test_single();
      bus.req          = 4'b0100;
      bus.data[23:16]  = 8'hA5;
      step();
      chk("single_grant", {4'b0, bus.grant}, 8'h04);
      chk("single_led", bus.led, 8'hA5);
      bus.data[23:16] = 8'h3C;
      step();
      chk("single_led_update", bus.led, 8'h3C);
      chk("single_grant_hold", {4'b0, bus.grant}, 8'h04);
   endtask

   task automatic test_release();
      bus.req = 4'b0010;
      step();
      chk("release_grant", {4'b0, bus.grant}, 8'h00);
      chk("release_led", bus.led, 8'h00);
      chk("release_busy", {7'b0, bus.busy}, 8'h00);
      step();
      chk("rearb_grant", {4'b0, bus.grant}, 8'h02);
      chk("rearb_led", bus.led, 8'h22);
      bus.req = 4'b0000;
      step();
      chk("release2_grant", {4'b0, bus.grant}, 8'h00);
   endtask

   task automatic test_preempt();
      logic [3:0] exp;
      bus.req = 4'b0011;
      for (int k = 0; k < 9; k++) begin
         step();
`ifdef LED_ARB_PREEMPT_EN
         exp = (((k / 4) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
         exp = 4'b0001;
`endif
         chk($sformatf("preempt_grant_k%0d", k), {4'b0, bus.grant}, {4'b0, exp});
         chk($sformatf("preempt_busy_k%0d", k), {7'b0, bus.busy}, 8'h01);
      end
      bus.req = 4'b0000;
      step();
      chk("preempt_idle", {4'b0, bus.grant}, 8'h00);
   endtask

   task automatic test_coincidence();
      bus.req = 4'b0001;
      step();
      chk("coinc_grant0", {4'b0, bus.grant}, 8'h01);
      step();
      step();
      step();
      chk("coinc_hold", {4'b0, bus.grant}, 8'h01);
      bus.req = 4'b1000;
      step();
      chk("coinc_gap_grant", {4'b0, bus.grant}, 8'h00);
      chk("coinc_gap_busy", {7'b0, bus.busy}, 8'h00);
      step();
      chk("coinc_grant3", {4'b0, bus.grant}, 8'h08);
      chk("coinc_led3", bus.led, 8'h44);
   endtask

   task automatic test_wrap();
      bus.req = 4'b0000;
      step();
      bus.req = 4'b1001;
      step();
      chk("wrap_grant", {4'b0, bus.grant}, 8'h01);
      chk("wrap_led", bus.led, 8'h11);
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      step();
      chk("midreset_grant", {4'b0, bus.grant}, 8'h00);
      chk("midreset_led", bus.led, 8'h00);
      rst_n = 1'b1;
      step();
      chk("midreset_regrant", {4'b0, bus.grant}, 8'h01);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.data = '0;
      test_reset();
      test_single();
      test_release();
      test_preempt();
      test_coincidence();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
